// File: rtl/ssd_scan_driver_if.sv
// Bundles the display-side signals of the seven-segment scan driver.
//   value      : 16-bit hex word to display, digit 0 in value[3:0]
//   blank_lz   : 1 enables leading-zero blanking
//   seg7       : active-low segments {g,f,e,d,c,b,a}
//   select     : active-low digit enables, select[0] is the rightmost digit
//   frame_done : one-cycle pulse after each completed four-digit frame
// master: the word source and display consumer; slave: the scan driver itself.
interface ssd_scan_driver_if;
  logic [15:0] value;
  logic        blank_lz;
  logic [6:0]  seg7;
  logic [3:0]  select;
  logic        frame_done;

  modport master (
    output value,
    output blank_lz,
    input  seg7,
    input  select,
    input  frame_done
  );

  modport slave (
    input  value,
    input  blank_lz,
    output seg7,
    output select,
    output frame_done
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Each digit owns REFRESH_DIV clock cycles. The first cycle of every slot is
// blanked so the previous digit's segments never bleed onto the new digit.
// The displayed word is captured only when the scan wraps from digit 3 back to
// digit 0, so one frame always shows a single coherent word.
// Ports:
//   clk : system clock, rising-edge
//   clr : asynchronous active-high reset
//   bus : ssd_scan_driver_if.slave (value, blank_lz in; seg7, select, frame_done out)
module ssd_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000  // clk cycles per digit slot, 2..65535
) (
  input logic              clk,
  input logic              clr,
  ssd_scan_driver_if.slave bus
);

  localparam logic [15:0] CntMax = 16'(REFRESH_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  select_q, select_d;
  logic [6:0]  seg7_q, seg7_d;
  logic        frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic [3:0] nibble;
  logic       blank_digit;
  logic [6:0] glyph;

  assign tick = (cnt_q == CntMax);
  assign wrap = tick && (idx_q == 2'd3);

  // Nibble under the current index plus its leading-zero status: digit k is
  // blank when it and every digit above it are zero. Digit 0 always shows.
  always_comb begin
    nibble      = 4'h0;
    blank_digit = 1'b0;
    unique case (idx_q)
      2'd0: begin
        nibble      = word_q[3:0];
        blank_digit = 1'b0;
      end
      2'd1: begin
        nibble      = word_q[7:4];
        blank_digit = (word_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble      = word_q[11:8];
        blank_digit = (word_q[15:8] == 8'h00);
      end
      2'd3: begin
        nibble      = word_q[15:12];
        blank_digit = (word_q[15:12] == 4'h0);
      end
      default: begin
        nibble      = 4'h0;
        blank_digit = 1'b0;
      end
    endcase
    blank_digit = blank_digit && bus.blank_lz;
  end

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    glyph = 7'b1111111;
    unique case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  end

  always_comb begin
    cnt_d        = tick ? 16'h0000 : cnt_q + 16'h0001;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    word_d       = wrap ? bus.value : word_q;
    frame_done_d = wrap;
    select_d     = 4'b1111;
    seg7_d       = 7'b1111111;
    // Outputs for the slot follow the index one cycle late; the tick cycle
    // itself is the anti-ghosting blank.
    if (!tick && !blank_digit) begin
      select_d = ~(4'b0001 << idx_q);
      seg7_d   = glyph;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q        <= 16'h0000;
      idx_q        <= 2'd0;
      word_q       <= 16'h0000;
      select_q     <= 4'b1111;
      seg7_q       <= 7'b1111111;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      select_q     <= select_d;
      seg7_q       <= seg7_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.select     = select_q;
  assign bus.seg7       = seg7_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the number of clk cycles per digit slot (legal range 2..65535).
REQ-002 Port clk SHALL be an input of width 1: the single system clock, with all state rising-edge triggered.
REQ-003 Port clr SHALL be an input of width 1: asynchronous, active-high reset.
REQ-004 Port value SHALL be an input of width 16: the hex word to display, taken from the mux2_to_1_16bit output; digit 0 is value[3:0].
REQ-005 Port blank_lz SHALL be an input of width 1: 1 enables leading-zero blanking.
REQ-006 Port seg7 SHALL be an output of width 7: active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-007 Port select SHALL be an output of width 4: active-low digit enables; select[0] is the rightmost digit.
REQ-008 Port frame_done SHALL be an output of width 1: a one-cycle pulse at each frame boundary.

Function
REQ-009 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is 1 when the count equals REFRESH_DIV-1.
REQ-010 The 2-bit digit index SHALL advance 0->1->2->3->0 on every tick edge and hold otherwise.
REQ-011 The value latch SHALL load from value only on the tick edge where the index wraps 3->0, so a frame never mixes two words.
REQ-012 frame_done SHALL be 1 for exactly the one cycle following a 3->0 wrap edge and 0 otherwise.
REQ-013 seg7 and select SHALL be registered.
REQ-014 On a tick edge, select SHALL load 4'b1111 and seg7 SHALL load 7'b1111111 (one-cycle anti-ghosting blank).
REQ-015 On a non-tick edge, select SHALL load one-hot-low for the current index and seg7 SHALL load the glyph of the latched nibble at that index.
REQ-016 A newly selected digit SHALL therefore appear one cycle after its index change.
REQ-017 The glyph table SHALL cover hex 0-F; required codes are 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-018 With blank_lz=1, digit k (k=3,2,1) SHALL be blanked when latched nibbles k..3 are all zero; a blanked digit drives select=1111 and seg7=1111111 for its slot.
REQ-019 Digit 0 SHALL never be blanked, so a value of 0 displays a single "0".
REQ-020 blank_lz SHALL be sampled combinationally each cycle; a change SHALL take effect at the next non-tick edge.
REQ-021 Changes on value outside the wrap edge SHALL have no effect on the display.
REQ-022 The prescaler SHALL never stall; there is no enable.

Reset
REQ-023 While clr=1, the prescaler count SHALL be 0, the index 0, the value latch 16'h0000, select 4'b1111, seg7 7'b1111111 and frame_done 0, asynchronously.
REQ-024 On the first edge after clr falls, outputs SHALL show digit 0 of 16'h0000: select=1110, seg7=1000000.
REQ-025 A clr asserted mid-frame SHALL discard the partial frame; no frame_done pulse is issued for it.
REQ-026 The first new value SHALL be captured at the first 3->0 wrap after reset, 4*REFRESH_DIV cycles after reset release.

Verification (REFRESH_DIV=4)
REQ-027 Reset, then value=16'h1234 and blank_lz=0: first frame shows 0000; from the first wrap, per-slot select 1110/1101/1011/0111 carries seg7 for 4/3/2/1, and frame_done pulses every 16 cycles.
REQ-028 Cadence: each slot shows exactly one cycle of select=1111 followed by 3 cycles of the digit; the check covers the 3->0 wrap slot.
REQ-029 value=16'h00A0, blank_lz=1: digits 3 and 2 are blanked; digit 1 shows A (0001000); digit 0 shows 0 (1000000).
REQ-030 value=16'h0000, blank_lz=1: only the select=1110 slot is active, showing 1000000; all other slots stay 1111.
REQ-031 Set value=16'h8888, then change it to 16'hFFFF mid-frame: the rest of the frame still shows 8 (0000000); F (0001110) appears only after the next wrap.
REQ-032 Assert clr during the digit-2 slot: outputs go to 1111/1111111 immediately with no clk edge; on release, scanning restarts at digit 0 with the latch cleared and no spurious frame_done pulse.
